// File: rtl/icache_direct_mapped_pkg.sv
// Shared types and constants for the direct-mapped instruction cache.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state encoding, line/word/offset widths, tag-width helper.
package icache_direct_mapped_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    ALLOCATE = 1'b1
  } state_t;

  localparam int LINE_W   = 128;
  localparam int WORD_W   = 32;
  localparam int OFFSET_W = 2;

  // Tag bits left over once the word offset and the index are removed.
  function automatic int tag_width(input int addr_w, input int idx_w);
    return addr_w - OFFSET_W - idx_w;
  endfunction

endpackage

// File: rtl/icache_line_store.sv
// Valid/tag/data arrays of the direct-mapped instruction cache.
// Latency: read port is combinational; refill write lands on the next clk edge.
// Backpressure: none, the single write port always accepts.
// Ports: clk/rst_n; wr_en/wr_idx/wr_tag/wr_line refill port;
//        rd_idx/rd_off in, rd_valid/rd_tag/rd_word out for the lookup port.
module icache_line_store
  import icache_direct_mapped_pkg::*;
#(
  parameter int NUM_BLOCKS = 8,
  parameter int IDX_W      = 3,
  parameter int TAG_W      = 25
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [IDX_W-1:0]    wr_idx,
  input  logic [TAG_W-1:0]    wr_tag,
  input  logic [LINE_W-1:0]   wr_line,
  input  logic [IDX_W-1:0]    rd_idx,
  input  logic [OFFSET_W-1:0] rd_off,
  output logic                rd_valid,
  output logic [TAG_W-1:0]    rd_tag,
  output logic [WORD_W-1:0]   rd_word
);

  logic [NUM_BLOCKS-1:0] valid_q;
  logic [TAG_W-1:0]      tag_mem  [NUM_BLOCKS];
  logic [LINE_W-1:0]     data_mem [NUM_BLOCKS];
  logic [LINE_W-1:0]     rd_line;

  // Only the valid bits need a reset; tag/data are qualified by them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_line;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_mem[rd_idx];
  assign rd_line  = data_mem[rd_idx];
  // Word n sits at bits [32n+31:32n]; {off,5'b0} is 32*off.
  assign rd_word  = rd_line[{rd_off, 5'b0} +: WORD_W];

endmodule

// File: rtl/icache_direct_mapped.sv
// Read-only direct-mapped instruction cache between the IF stage and instruction memory.
// Latency: hits return data combinationally in the request cycle; a miss costs >= 2 cycles.
// Backpressure: proc_stall holds the fetch stage; refill waits on the mem_ready pulse indefinitely.
// Ports: clk, rst_n (sync, active-low); proc_read/proc_addr in, proc_rdata/proc_stall out;
//        mem_read/mem_addr out (registered), mem_rdata/mem_ready in.
module icache_direct_mapped
  import icache_direct_mapped_pkg::*;
#(
  parameter int NUM_BLOCKS = 8,
  parameter int ADDR_W     = 30
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                proc_read,
  input  logic [ADDR_W-1:0]   proc_addr,
  output logic [WORD_W-1:0]   proc_rdata,
  output logic                proc_stall,
  output logic                mem_read,
  output logic [ADDR_W-3:0]   mem_addr,
  input  logic [LINE_W-1:0]   mem_rdata,
  input  logic                mem_ready
);

  localparam int IDX_W = $clog2(NUM_BLOCKS);
  localparam int TAG_W = tag_width(ADDR_W, IDX_W);

  state_t              state;
  logic [ADDR_W-3:0]   line_addr_q;   // latched line address, also drives mem_addr

  logic [OFFSET_W-1:0] req_off;
  logic [IDX_W-1:0]    req_idx;
  logic [TAG_W-1:0]    req_tag;
  logic                rd_valid;
  logic [TAG_W-1:0]    rd_tag;
  logic [WORD_W-1:0]   rd_word;
  logic                hit;
  logic                refill_we;

  assign req_off = proc_addr[OFFSET_W-1:0];
  assign req_idx = proc_addr[IDX_W+OFFSET_W-1:OFFSET_W];
  assign req_tag = proc_addr[ADDR_W-1:IDX_W+OFFSET_W];

  assign hit       = proc_read && rd_valid && (rd_tag == req_tag);
  assign refill_we = (state == ALLOCATE) && mem_ready;

  icache_line_store #(
    .NUM_BLOCKS (NUM_BLOCKS),
    .IDX_W      (IDX_W),
    .TAG_W      (TAG_W)
  ) u_line_store (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (refill_we),
    .wr_idx   (line_addr_q[IDX_W-1:0]),
    .wr_tag   (line_addr_q[ADDR_W-3:IDX_W]),
    .wr_line  (mem_rdata),
    .rd_idx   (req_idx),
    .rd_off   (req_off),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_word  (rd_word)
  );

  // The refill cycle itself still stalls; the fetch is replayed from the
  // first IDLE cycle against whatever proc_addr is then presented.
  assign proc_stall = (state == ALLOCATE) || (proc_read && !hit);
  assign proc_rdata = ((state == IDLE) && hit) ? rd_word : '0;
  assign mem_addr   = line_addr_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      mem_read    <= 1'b0;
      line_addr_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (proc_read && !hit) begin
            line_addr_q <= proc_addr[ADDR_W-1:OFFSET_W];
            mem_read    <= 1'b1;
            state       <= ALLOCATE;
          end
        end
        ALLOCATE: begin
          if (mem_ready) begin
            mem_read <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          mem_read <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule
